// File: rtl/pipe_mult.sv
// pipe_mult: WIDTH x WIDTH signed/unsigned multiplier, 3 registered stages; result visible 3 cycles after acceptance.
// One global enable stalls every stage while p is held (in_ready = !out_valid || out_ready); `MULT_ACC_EN adds a MAC accumulator.
module pipe_mult #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
`ifdef MULT_ACC_EN
   input  logic               acc_clr,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);
   localparam int HW = WIDTH / 2;
   localparam int PW = 2 * WIDTH;

   logic en;

   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_sgn_q, s1_sgn_d;

   logic             s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0] s2_a_q, s2_a_d;
   logic [WIDTH-1:0] s2_b_q, s2_b_d;
   logic             s2_sgn_q, s2_sgn_d;
   logic [WIDTH-1:0] pp_ll_q, pp_ll_d;
   logic [WIDTH-1:0] pp_hl_q, pp_hl_d;
   logic [WIDTH-1:0] pp_lh_q, pp_lh_d;
   logic [WIDTH-1:0] pp_hh_q, pp_hh_d;

   logic             out_vld_q, out_vld_d;
   logic [PW-1:0]    p_q, p_d;

   logic [PW-1:0]    u;
   logic [PW-1:0]    prod;

`ifdef MULT_ACC_EN
   logic             s1_clr_q, s1_clr_d;
   logic             s2_clr_q, s2_clr_d;
`endif

   assign en        = !out_vld_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_vld_q;
   assign p         = p_q;

   // Unsigned product from the four partials, then subtract the sign-bit weights for two's complement.
   always_comb begin
      u = {{WIDTH{1'b0}}, pp_ll_q}
        + ({{WIDTH{1'b0}}, pp_hl_q} << HW)
        + ({{WIDTH{1'b0}}, pp_lh_q} << HW)
        + {pp_hh_q, {WIDTH{1'b0}}};
      prod = u;
      if (s2_sgn_q) begin
         if (s2_a_q[WIDTH-1]) prod = prod - {s2_b_q, {WIDTH{1'b0}}};
         if (s2_b_q[WIDTH-1]) prod = prod - {s2_a_q, {WIDTH{1'b0}}};
      end
   end

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_sgn_d  = s1_sgn_q;
      s2_vld_d  = s2_vld_q;
      s2_a_d    = s2_a_q;
      s2_b_d    = s2_b_q;
      s2_sgn_d  = s2_sgn_q;
      pp_ll_d   = pp_ll_q;
      pp_hl_d   = pp_hl_q;
      pp_lh_d   = pp_lh_q;
      pp_hh_d   = pp_hh_q;
      out_vld_d = out_vld_q;
      p_d       = p_q;
`ifdef MULT_ACC_EN
      s1_clr_d  = s1_clr_q;
      s2_clr_d  = s2_clr_q;
`endif
      if (en) begin
         s1_vld_d  = in_valid;
         s1_a_d    = a;
         s1_b_d    = b;
         s1_sgn_d  = is_signed;

         s2_vld_d  = s1_vld_q;
         s2_a_d    = s1_a_q;
         s2_b_d    = s1_b_q;
         s2_sgn_d  = s1_sgn_q;
         pp_ll_d   = {{HW{1'b0}}, s1_a_q[HW-1:0]}     * {{HW{1'b0}}, s1_b_q[HW-1:0]};
         pp_hl_d   = {{HW{1'b0}}, s1_a_q[WIDTH-1:HW]} * {{HW{1'b0}}, s1_b_q[HW-1:0]};
         pp_lh_d   = {{HW{1'b0}}, s1_a_q[HW-1:0]}     * {{HW{1'b0}}, s1_b_q[WIDTH-1:HW]};
         pp_hh_d   = {{HW{1'b0}}, s1_a_q[WIDTH-1:HW]} * {{HW{1'b0}}, s1_b_q[WIDTH-1:HW]};

         out_vld_d = s2_vld_q;
`ifdef MULT_ACC_EN
         s1_clr_d  = acc_clr;
         s2_clr_d  = s1_clr_q;
         // p_q doubles as the accumulator; bubbles leave it untouched.
         if (s2_vld_q) p_d = (s2_clr_q ? {PW{1'b0}} : p_q) + prod;
`else
         if (s2_vld_q) p_d = prod;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_sgn_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_a_q    <= '0;
         s2_b_q    <= '0;
         s2_sgn_q  <= 1'b0;
         pp_ll_q   <= '0;
         pp_hl_q   <= '0;
         pp_lh_q   <= '0;
         pp_hh_q   <= '0;
         out_vld_q <= 1'b0;
         p_q       <= '0;
`ifdef MULT_ACC_EN
         s1_clr_q  <= 1'b0;
         s2_clr_q  <= 1'b0;
`endif
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_sgn_q  <= s1_sgn_d;
         s2_vld_q  <= s2_vld_d;
         s2_a_q    <= s2_a_d;
         s2_b_q    <= s2_b_d;
         s2_sgn_q  <= s2_sgn_d;
         pp_ll_q   <= pp_ll_d;
         pp_hl_q   <= pp_hl_d;
         pp_lh_q   <= pp_lh_d;
         pp_hh_q   <= pp_hh_d;
         out_vld_q <= out_vld_d;
         p_q       <= p_d;
`ifdef MULT_ACC_EN
         s1_clr_q  <= s1_clr_d;
         s2_clr_q  <= s2_clr_d;
`endif
      end
   end

endmodule
